// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared ternary PWM code and sample-format definitions
package dsm_pkg;

  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_NEG  = 2'b11;
  localparam logic [1:0] PWM_ZERO = 2'b00;
  localparam logic [1:0] PWM_INV  = 2'b10;

  localparam int DSM_SAMPLE_W = 15;
  localparam logic signed [DSM_SAMPLE_W-1:0] DSM_SAMPLE_MAX = 15'sh3fff;
  localparam logic signed [DSM_SAMPLE_W-1:0] DSM_SAMPLE_MIN = 15'sh4000;

  // Invalid code deliberately folds to zero so a glitch never biases the mean.
  function automatic logic signed [1:0] pwm_to_x(input logic [1:0] code);
    logic signed [1:0] v;
    v = 2'sb00;
    case (code)
      PWM_POS: v = 2'sb01;
      PWM_NEG: v = 2'sb11;
      default: v = 2'sb00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dsm_demod_comb.sv
// rtl/dsm_demod_comb.sv - 3-stage CIC comb with gain normalisation and saturation
module dsm_demod_comb
  import dsm_pkg::*;
#(
  parameter int W = 11,
  parameter int S = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [W-1:0]            din,
  output logic [DSM_SAMPLE_W-1:0] dout
);

  localparam int SW = W + S;
  localparam logic signed [SW-1:0] HI = SW'(DSM_SAMPLE_MAX);
  localparam logic signed [SW-1:0] LO = SW'(DSM_SAMPLE_MIN);

  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] c1, c2, c3;
  logic signed [SW-1:0] scaled;
  logic [DSM_SAMPLE_W-1:0] sat;

  // Differences are taken mod 2^W; integrator wrap cancels out here.
  assign c1 = din - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  assign scaled = {c3, {S{1'b0}}};

  always_comb begin
    sat = scaled[DSM_SAMPLE_W-1:0];
    if (scaled > HI) begin
      sat = DSM_SAMPLE_MAX;
    end else if (scaled < LO) begin
      sat = DSM_SAMPLE_MIN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      dout <= '0;
    end else if (tick) begin
      d1   <= din;
      d2   <= c1;
      d3   <= c2;
      dout <= sat;
    end
  end

endmodule

// File: rtl/dsm_demod.sv
// rtl/dsm_demod.sv - ternary delta-sigma demodulator with 3rd-order CIC decimator
// Optional invalid-code counter port err_cnt enabled by DSM_DEMOD_ERR_EN.
module dsm_demod
  import dsm_pkg::*;
#(
  parameter int DECIM = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              pwm,
  output logic [DSM_SAMPLE_W-1:0] dout,
  output logic                    dout_valid
`ifdef DSM_DEMOD_ERR_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  localparam int L = $clog2(DECIM);
  localparam int W = 2 + 3 * L;
  localparam int S = 14 - 3 * L;

  logic signed [1:0] x;
  logic [W-1:0]      i1, i2, i3;
  logic [L-1:0]      dcnt;
  logic              tick;

  assign tick = (dcnt == L'(DECIM - 1));

  // Integrators wrap freely at W bits; the comb differences recover the sum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x          <= 2'sb00;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      dcnt       <= '0;
      dout_valid <= 1'b0;
    end else begin
      x          <= pwm_to_x(pwm);
      i1         <= i1 + W'(x);
      i2         <= i2 + i1;
      i3         <= i3 + i2;
      dcnt       <= dcnt + L'(1);
      dout_valid <= tick;
    end
  end

  dsm_demod_comb #(
    .W(W),
    .S(S)
  ) u_comb (
    .clock(clock),
    .reset(reset),
    .tick (tick),
    .din  (i3),
    .dout (dout)
  );

`ifdef DSM_DEMOD_ERR_EN
  logic x_inv;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_inv   <= 1'b0;
      err_cnt <= '0;
    end else begin
      x_inv <= (pwm == PWM_INV);
      if (x_inv && (err_cnt != 8'hff)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
